// File: rtl/status_array_mgr.sv
// Status array with self-initialisation: a 2^ADDR_WIDTH x ROW_WIDTH store of per-field
// status bits, masked row writes, 1-cycle tagged reads with write-first forwarding.
module status_array_mgr #(
    parameter int                    TAG_WIDTH  = 1,
    parameter int                    ADDR_WIDTH = 4,
    parameter int                    NUM_BLOCKS = 4,
    parameter int                    BLOCK_BITS = 2,
    parameter logic [BLOCK_BITS-1:0] INIT_VALUE = '0
) (
    input  logic                             clk,
    input  logic                             arst,
    input  logic                             i_halt,
    input  logic                             i_flush,
    input  logic [TAG_WIDTH-1:0]             i_tag,
    input  logic [ADDR_WIDTH-1:0]            i_r_addr,
    input  logic                             i_r_valid,
    input  logic [ADDR_WIDTH-1:0]            i_w_addr,
    input  logic [NUM_BLOCKS*BLOCK_BITS-1:0] i_w_data,
    input  logic [NUM_BLOCKS-1:0]            i_w_wmask,
    input  logic                             i_w_valid,
    output logic [TAG_WIDTH-1:0]             o_tag,
    output logic [NUM_BLOCKS*BLOCK_BITS-1:0] o_data,
    output logic                             o_valid,
    output logic                             o_ready,
    output logic                             o_init_busy
);

    localparam int ROW_WIDTH = NUM_BLOCKS * BLOCK_BITS;
    localparam int DEPTH     = 1 << ADDR_WIDTH;

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    localparam logic [ADDR_WIDTH-1:0] LAST_ROW = {ADDR_WIDTH{1'b1}};
    localparam logic [ROW_WIDTH-1:0]  INIT_ROW = {NUM_BLOCKS{INIT_VALUE}};

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q,   cnt_d;
    logic                  valid_q, valid_d;
    logic [ROW_WIDTH-1:0]  data_q,  data_d;
    logic [TAG_WIDTH-1:0]  tag_q,   tag_d;

    logic [ROW_WIDTH-1:0]  mem_q [DEPTH];

    logic                  active;
    logic                  w_accept;
    logic [ROW_WIDTH-1:0]  w_row;
    logic [ROW_WIDTH-1:0]  rd_row;

    // Flush wins over any read or write presented in the same cycle.
    assign active   = (state_q == ST_READY) && !i_halt && !i_flush;
    assign w_accept = active && i_w_valid;

    // NOTE: every always_comb output gets a default before any branch, so no path can infer a latch.
    always_comb begin
        w_row = mem_q[i_w_addr];
        for (int k = 0; k < NUM_BLOCKS; k++) begin
            if (i_w_wmask[k]) begin
                w_row[k*BLOCK_BITS +: BLOCK_BITS] = i_w_data[k*BLOCK_BITS +: BLOCK_BITS];
            end
        end
        rd_row = (w_accept && (i_w_addr == i_r_addr)) ? w_row : mem_q[i_r_addr];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        data_d  = data_q;
        tag_d   = tag_q;
        if (!i_halt) begin
            valid_d = 1'b0;
            if (state_q == ST_INIT) begin
                if (i_flush) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                    if (cnt_q == LAST_ROW) begin
                        state_d = ST_READY;
                    end
                end
            end else if (i_flush) begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end else if (i_r_valid) begin
                valid_d = 1'b1;
                data_d  = rd_row;
                tag_d   = i_tag;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
        end
    end

    // NOTE: the storage has no reset; the INIT sweep rewrites every row after each reset or flush.
    always_ff @(posedge clk) begin
        if (!i_halt) begin
            if (state_q == ST_INIT) begin
                mem_q[cnt_q] <= INIT_ROW;
            end else if (w_accept) begin
                mem_q[i_w_addr] <= w_row;
            end
        end
    end

    assign o_tag       = tag_q;
    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_ready     = (state_q == ST_READY) && !i_halt;
    assign o_init_busy = (state_q == ST_INIT);

endmodule

// File: tb/tb_status_array_mgr.sv
// Directed bench for status_array_mgr (default parameters): vector table for the
// read/write datapath plus hand sequences for INIT length, halt, flush and reset.
module tb_status_array_mgr;

    logic       clk = 1'b0;
    logic       arst;
    logic       i_halt, i_flush, i_r_valid, i_w_valid;
    logic [0:0] i_tag;
    logic [3:0] i_r_addr, i_w_addr, i_w_wmask;
    logic [7:0] i_w_data;
    logic [0:0] o_tag;
    logic [7:0] o_data;
    logic       o_valid, o_ready, o_init_busy;

    int errors = 0;
    int checks = 0;
    int n;

    always #5 clk = ~clk;

    status_array_mgr dut (
        .clk        (clk),
        .arst       (arst),
        .i_halt     (i_halt),
        .i_flush    (i_flush),
        .i_tag      (i_tag),
        .i_r_addr   (i_r_addr),
        .i_r_valid  (i_r_valid),
        .i_w_addr   (i_w_addr),
        .i_w_data   (i_w_data),
        .i_w_wmask  (i_w_wmask),
        .i_w_valid  (i_w_valid),
        .o_tag      (o_tag),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_ready    (o_ready),
        .o_init_busy(o_init_busy)
    );

    typedef struct {
        logic       w_valid;
        logic [3:0] w_addr;
        logic [7:0] w_data;
        logic [3:0] w_mask;
        logic       r_valid;
        logic [3:0] r_addr;
        logic       tag;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_tag;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_halt    = 1'b0;
        i_flush   = 1'b0;
        i_r_valid = 1'b0;
        i_w_valid = 1'b0;
        i_tag     = '0;
        i_r_addr  = '0;
        i_w_addr  = '0;
        i_w_data  = '0;
        i_w_wmask = '0;
    endtask

    // Counts cycles spent with o_init_busy high, optionally halting for a window.
    task automatic count_init(input int halt_from, input int halt_len, output int cycles);
        cycles = 0;
        while (o_init_busy && cycles < 100) begin
            i_halt = (cycles >= halt_from) && (cycles < halt_from + halt_len);
            step();
            cycles++;
        end
        i_halt = 1'b0;
    endtask

    task automatic read_row(input logic [3:0] addr, input logic tag);
        i_r_valid = 1'b1;
        i_r_addr  = addr;
        i_tag     = tag;
        step();
        i_r_valid = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 4'd3, 8'hFF, 4'b0101, 1'b0, 4'd0,  1'b0, 1'b0, 8'h00, 1'b0};
        vecs[1]  = '{1'b0, 4'd0, 8'h00, 4'b0000, 1'b1, 4'd3,  1'b0, 1'b1, 8'h33, 1'b0};
        vecs[2]  = '{1'b1, 4'd5, 8'hAA, 4'b1111, 1'b1, 4'd5,  1'b1, 1'b1, 8'hAA, 1'b1};
        vecs[3]  = '{1'b0, 4'd0, 8'h00, 4'b0000, 1'b1, 4'd5,  1'b0, 1'b1, 8'hAA, 1'b0};
        vecs[4]  = '{1'b1, 4'd6, 8'h0F, 4'b0011, 1'b1, 4'd6,  1'b1, 1'b1, 8'h0F, 1'b1};
        vecs[5]  = '{1'b1, 4'd6, 8'hF0, 4'b1100, 1'b1, 4'd7,  1'b0, 1'b1, 8'h00, 1'b0};
        vecs[6]  = '{1'b0, 4'd0, 8'h00, 4'b0000, 1'b1, 4'd6,  1'b1, 1'b1, 8'hFF, 1'b1};
        vecs[7]  = '{1'b1, 4'd6, 8'h00, 4'b0010, 1'b1, 4'd6,  1'b0, 1'b1, 8'hF3, 1'b0};
        vecs[8]  = '{1'b0, 4'd0, 8'h00, 4'b0000, 1'b0, 4'd0,  1'b0, 1'b0, 8'h00, 1'b0};
        vecs[9]  = '{1'b0, 4'd0, 8'h00, 4'b0000, 1'b1, 4'd3,  1'b1, 1'b1, 8'h33, 1'b1};
        vecs[10] = '{1'b1, 4'd3, 8'hC0, 4'b1000, 1'b1, 4'd3,  1'b0, 1'b1, 8'hF3, 1'b0};
        vecs[11] = '{1'b0, 4'd0, 8'h00, 4'b0000, 1'b1, 4'd15, 1'b1, 1'b1, 8'h00, 1'b1};

        idle_inputs();
        arst = 1'b1;
        #23;
        check("reset_valid", 32'(o_valid), 32'd0);
        check("reset_data", 32'(o_data), 32'h00);
        check("reset_tag", 32'(o_tag), 32'd0);
        check("reset_ready", 32'(o_ready), 32'd0);
        check("reset_busy", 32'(o_init_busy), 32'd1);
        step();
        arst = 1'b0;

        // Full INIT after reset release, then every row reads back INIT_VALUE.
        count_init(100, 0, n);
        check("init_len", 32'(n), 32'd16);
        check("init_ready", 32'(o_ready), 32'd1);
        for (int r = 0; r < 16; r++) begin
            read_row(4'(r), 1'(r));
            check("init_row_valid", 32'(o_valid), 32'd1);
            check("init_row_data", 32'(o_data), 32'h00);
            check("init_row_tag", 32'(o_tag), 32'(r % 2));
        end

        for (int v = 0; v < 12; v++) begin
            i_w_valid = vecs[v].w_valid;
            i_w_addr  = vecs[v].w_addr;
            i_w_data  = vecs[v].w_data;
            i_w_wmask = vecs[v].w_mask;
            i_r_valid = vecs[v].r_valid;
            i_r_addr  = vecs[v].r_addr;
            i_tag     = vecs[v].tag;
            step();
            check($sformatf("vec%0d_valid", v), 32'(o_valid), 32'(vecs[v].exp_valid));
            if (vecs[v].exp_valid) begin
                check($sformatf("vec%0d_data", v), 32'(o_data), 32'(vecs[v].exp_data));
                check($sformatf("vec%0d_tag", v), 32'(o_tag), 32'(vecs[v].exp_tag));
            end
        end
        idle_inputs();

        // Halt holds a valid response and drops the write and read presented meanwhile.
        read_row(4'd3, 1'b1);
        check("pre_halt_data", 32'(o_data), 32'hF3);
        i_halt    = 1'b1;
        i_r_valid = 1'b1;
        i_r_addr  = 4'd5;
        i_tag     = 1'b0;
        i_w_valid = 1'b1;
        i_w_addr  = 4'd3;
        i_w_data  = 8'h00;
        i_w_wmask = 4'b1111;
        step();
        step();
        check("halt_valid", 32'(o_valid), 32'd1);
        check("halt_data", 32'(o_data), 32'hF3);
        check("halt_tag", 32'(o_tag), 32'd1);
        check("halt_ready", 32'(o_ready), 32'd0);
        idle_inputs();
        read_row(4'd3, 1'b0);
        check("halt_write_dropped", 32'(o_data), 32'hF3);
        step();
        check("idle_valid", 32'(o_valid), 32'd0);
        check("idle_data_hold", 32'(o_data), 32'hF3);

        // Flush drops a same-cycle read and re-initialises the array.
        i_w_valid = 1'b1;
        i_w_addr  = 4'd2;
        i_w_data  = 8'h55;
        i_w_wmask = 4'b1111;
        step();
        idle_inputs();
        i_flush   = 1'b1;
        i_r_valid = 1'b1;
        i_r_addr  = 4'd2;
        i_tag     = 1'b1;
        step();
        idle_inputs();
        check("flush_no_resp", 32'(o_valid), 32'd0);
        check("flush_busy", 32'(o_init_busy), 32'd1);
        count_init(100, 0, n);
        check("flush_init_len", 32'(n), 32'd16);
        read_row(4'd2, 1'b0);
        check("flush_row2", 32'(o_data), 32'h00);

        // Flush in INIT restarts the sweep from row 0.
        i_w_valid = 1'b1;
        i_w_addr  = 4'd9;
        i_w_data  = 8'hFF;
        i_w_wmask = 4'b1111;
        i_r_valid = 1'b1;
        i_r_addr  = 4'd9;
        i_tag     = 1'b1;
        step();
        idle_inputs();
        check("row9_fwd", 32'(o_data), 32'hFF);
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        for (int i = 0; i < 4; i++) step();
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        count_init(100, 0, n);
        check("reflush_init_len", 32'(n), 32'd16);

        // Reset at counter 9 clears outputs at once; the next INIT includes a 3-cycle halt at counter 7.
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        for (int i = 0; i < 9; i++) step();
        check("pre_arst_busy", 32'(o_init_busy), 32'd1);
        arst = 1'b1;
        #1;
        check("arst_data", 32'(o_data), 32'h00);
        check("arst_tag", 32'(o_tag), 32'd0);
        check("arst_valid", 32'(o_valid), 32'd0);
        check("arst_ready", 32'(o_ready), 32'd0);
        check("arst_busy", 32'(o_init_busy), 32'd1);
        step();
        step();
        arst = 1'b0;
        count_init(7, 3, n);
        check("halted_init_len", 32'(n), 32'd19);
        check("post_arst_ready", 32'(o_ready), 32'd1);
        read_row(4'd9, 1'b1);
        check("post_arst_row9", 32'(o_data), 32'h00);
        check("post_arst_tag", 32'(o_tag), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got no summary expected summary");
        $fatal(1);
    end

endmodule
